// File: rtl/bus_mem_ctrl.sv
// CPU-side memory controller: word RAM plus a memory-mapped interval timer,
// served over a shared tri-state data bus with a readM/inputReady handshake.
module bus_mem_ctrl #(
    parameter int    WORD_SIZE = 16,
    parameter int    DEPTH     = 256,
    parameter int    LATENCY   = 1,
    parameter int    IRQ_PULSE = 2,
    parameter string INIT_FILE = ""
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 readM,
    input  logic                 writeM,
    input  logic [WORD_SIZE-1:0] address,
    inout  logic [WORD_SIZE-1:0] data,
    output logic                 inputReady,
    output logic                 irq
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [WORD_SIZE-1:0] DEPTH_W     = WORD_SIZE'(DEPTH);
    localparam logic [WORD_SIZE-1:0] PERIOD_ADDR = WORD_SIZE'(16'hFF00);
    localparam logic [WORD_SIZE-1:0] COUNT_ADDR  = WORD_SIZE'(16'hFF01);
    localparam logic [WORD_SIZE-1:0] CTRL_ADDR   = WORD_SIZE'(16'hFF02);
    localparam logic [WORD_SIZE-1:0] ONE         = WORD_SIZE'(1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

    state_t               state, state_next;
    logic [3:0]           wait_cnt, wait_cnt_next;
    logic                 capture;
    logic [WORD_SIZE-1:0] addr_q, rd_addr, rd_word, rdata;
    logic [WORD_SIZE-1:0] mem [DEPTH];
    logic [WORD_SIZE-1:0] period, count;
    logic                 enable, pending;
    logic [3:0]           pulse_cnt;
    logic                 wr_en, period_wr, ctrl_wr, tick, wrap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // With LATENCY=1 the request edge itself captures the word and enters READY.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        capture       = 1'b0;
        case (state)
            S_IDLE: begin
                if (readM) begin
                    if (LATENCY == 1) begin
                        state_next = S_READY;
                        capture    = 1'b1;
                    end else begin
                        state_next    = S_WAIT;
                        wait_cnt_next = 4'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                if (!readM) begin
                    state_next = S_IDLE;
                end else if (wait_cnt == 4'd1) begin
                    state_next = S_READY;
                    capture    = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            S_READY: begin
                if (!readM) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
            addr_q   <= '0;
            rdata    <= '0;
        end else begin
            wait_cnt <= wait_cnt_next;
            if (state == S_IDLE && readM) addr_q <= address;
            if (capture) rdata <= rd_word;
        end
    end

    // In IDLE the live address is decoded so a single-cycle read can capture directly.
    assign rd_addr = (state == S_IDLE) ? address : addr_q;

    always_comb begin
        rd_word = '0;
        if (rd_addr < DEPTH_W) begin
            rd_word = mem[rd_addr[AW-1:0]];
        end else begin
            case (rd_addr)
                PERIOD_ADDR: rd_word = period;
                COUNT_ADDR:  rd_word = count;
                CTRL_ADDR:   rd_word = {{(WORD_SIZE-2){1'b0}}, pending, enable};
                default:     rd_word = '0;
            endcase
        end
    end

    assign wr_en     = writeM && !readM && reset_n;
    assign period_wr = wr_en && (address == PERIOD_ADDR);
    assign ctrl_wr   = wr_en && (address == CTRL_ADDR);

    always_ff @(posedge clk) begin
        if (wr_en && (address < DEPTH_W)) mem[address[AW-1:0]] <= data;
    end

    assign tick = enable && (period != '0);
    assign wrap = tick && !period_wr && (count == period - ONE);

    // A wrap sets pending even if software clears it on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period    <= '0;
            count     <= '0;
            enable    <= 1'b0;
            pending   <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            if (period_wr) begin
                period <= data;
                count  <= '0;
            end else if (wrap) begin
                count <= '0;
            end else if (tick) begin
                count <= count + ONE;
            end
            if (ctrl_wr) enable <= data[0];
            if (wrap)                    pending <= 1'b1;
            else if (ctrl_wr && data[1]) pending <= 1'b0;
            if (wrap)                  pulse_cnt <= 4'(IRQ_PULSE);
            else if (pulse_cnt != 4'd0) pulse_cnt <= pulse_cnt - 4'd1;
        end
    end

    assign irq        = (pulse_cnt != 4'd0);
    assign inputReady = (state == S_READY);
    assign data       = (state == S_READY && readM && reset_n) ? rdata : 'z;

endmodule

// File: tb/tb_bus_mem_ctrl.sv
// Directed bench for bus_mem_ctrl: a LATENCY=1 instance for the table and timer
// sequences, and a LATENCY=4 instance for multi-cycle handshake and abort.
module tb_bus_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        readM = 1'b0, writeM = 1'b0, tb_drive = 1'b0;
    logic [15:0] address = '0, tb_data = '0;
    wire  [15:0] data;
    logic        inputReady, irq;

    logic        read4 = 1'b0, write4 = 1'b0, tb_drive4 = 1'b0;
    logic [15:0] addr4 = '0, tb_data4 = '0;
    wire  [15:0] data4;
    logic        ready4, irq4;

    int errors = 0;
    int checks = 0;
    int t = 0;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        rdy;
        logic        chk;
        logic [15:0] dat;
    } vec_t;

    vec_t vecs [22];

    always #5 clk = ~clk;

    // A released bus settles to zero through the pulldowns.
    assign data  = tb_drive  ? tb_data  : 16'hzzzz;
    assign data4 = tb_drive4 ? tb_data4 : 16'hzzzz;
    for (genvar g = 0; g < 16; g++) begin : g_pull
        pulldown (data[g]);
        pulldown (data4[g]);
    end

    bus_mem_ctrl #(.WORD_SIZE(16), .DEPTH(256), .LATENCY(1), .IRQ_PULSE(2)) dut (
        .clk(clk), .reset_n(reset_n), .readM(readM), .writeM(writeM),
        .address(address), .data(data), .inputReady(inputReady), .irq(irq)
    );

    bus_mem_ctrl #(.WORD_SIZE(16), .DEPTH(256), .LATENCY(4), .IRQ_PULSE(2)) dut4 (
        .clk(clk), .reset_n(reset_n), .readM(read4), .writeM(write4),
        .address(addr4), .data(data4), .inputReady(ready4), .irq(irq4)
    );

    function automatic vec_t mk(logic rd, logic wr, logic [15:0] a, logic [15:0] wd,
                                logic rdy, logic chk, logic [15:0] dat);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd;
        v.rdy = rdy; v.chk = chk; v.dat = dat;
        return v;
    endfunction

    function automatic logic irq_exp(int k);
        return (k >= 11) && (((k - 1) % 10 == 0) || ((k - 2) % 10 == 0));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [15:0] a, input logic [15:0] wd);
        readM    = rd;
        writeM   = wr;
        address  = a;
        tb_data  = wd;
        tb_drive = wr;
        step();
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    initial begin
        vecs[0]  = mk(1'b0, 1'b1, 16'd5,    16'h1234, 1'b0, 1'b0, 16'h0000);
        vecs[1]  = mk(1'b0, 1'b0, 16'd0,    16'h0000, 1'b0, 1'b1, 16'h0000);
        vecs[2]  = mk(1'b1, 1'b0, 16'd5,    16'h0000, 1'b1, 1'b1, 16'h1234);
        vecs[3]  = mk(1'b1, 1'b0, 16'd200,  16'h0000, 1'b1, 1'b1, 16'h1234);
        vecs[4]  = mk(1'b0, 1'b0, 16'd200,  16'h0000, 1'b0, 1'b1, 16'h0000);
        vecs[5]  = mk(1'b0, 1'b1, 16'd200,  16'hBEEF, 1'b0, 1'b0, 16'h0000);
        vecs[6]  = mk(1'b0, 1'b1, 16'd200,  16'hBEEF, 1'b0, 1'b0, 16'h0000);
        vecs[7]  = mk(1'b0, 1'b1, 16'd200,  16'hBEEF, 1'b0, 1'b0, 16'h0000);
        vecs[8]  = mk(1'b0, 1'b0, 16'd0,    16'h0000, 1'b0, 1'b1, 16'h0000);
        vecs[9]  = mk(1'b1, 1'b0, 16'd200,  16'h0000, 1'b1, 1'b1, 16'hBEEF);
        vecs[10] = mk(1'b0, 1'b0, 16'd0,    16'h0000, 1'b0, 1'b1, 16'h0000);
        vecs[11] = mk(1'b1, 1'b0, 16'h0300, 16'h0000, 1'b1, 1'b1, 16'h0000);
        vecs[12] = mk(1'b0, 1'b0, 16'd0,    16'h0000, 1'b0, 1'b0, 16'h0000);
        vecs[13] = mk(1'b0, 1'b1, 16'd201,  16'h1111, 1'b0, 1'b0, 16'h0000);
        vecs[14] = mk(1'b0, 1'b0, 16'd0,    16'h0000, 1'b0, 1'b0, 16'h0000);
        vecs[15] = mk(1'b1, 1'b0, 16'hFF00, 16'h0000, 1'b1, 1'b1, 16'h0000);
        vecs[16] = mk(1'b0, 1'b0, 16'd0,    16'h0000, 1'b0, 1'b0, 16'h0000);
        vecs[17] = mk(1'b0, 1'b1, 16'hFF01, 16'h0055, 1'b0, 1'b0, 16'h0000);
        vecs[18] = mk(1'b1, 1'b0, 16'hFF01, 16'h0000, 1'b1, 1'b1, 16'h0000);
        vecs[19] = mk(1'b0, 1'b0, 16'd0,    16'h0000, 1'b0, 1'b0, 16'h0000);
        vecs[20] = mk(1'b1, 1'b0, 16'd5,    16'h0000, 1'b1, 1'b1, 16'h1234);
        vecs[21] = mk(1'b0, 1'b0, 16'd0,    16'h0000, 1'b0, 1'b1, 16'h0000);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset inputReady", {15'b0, inputReady}, 16'h0000);
        checkOutput("reset irq",        {15'b0, irq},        16'h0000);
        checkOutput("reset data",       data,                16'h0000);
        checkOutput("reset ready4",     {15'b0, ready4},     16'h0000);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            checkOutput($sformatf("vec%0d ready", i), {15'b0, inputReady}, {15'b0, vecs[i].rdy});
            if (vecs[i].chk)
                checkOutput($sformatf("vec%0d data", i), data, vecs[i].dat);
        end

        // Simultaneous read and write: the write to 201 must be dropped.
        readM = 1'b1; writeM = 1'b1; address = 16'd201; tb_data = 16'h2222; tb_drive = 1'b1;
        @(posedge clk);
        tb_drive = 1'b0; writeM = 1'b0;
        #1;
        checkOutput("rd+wr ready", {15'b0, inputReady}, 16'h0001);
        checkOutput("rd+wr data", data, 16'h1111);
        applyStimulus(1'b0, 1'b0, 16'd0, 16'h0);
        applyStimulus(1'b1, 1'b0, 16'd201, 16'h0);
        checkOutput("ram201 kept", data, 16'h1111);
        applyStimulus(1'b0, 1'b0, 16'd0, 16'h0);

        // Timer: PERIOD=10 then enable; t counts edges from the enable write.
        applyStimulus(1'b0, 1'b1, 16'hFF00, 16'd10);
        applyStimulus(1'b0, 1'b1, 16'hFF02, 16'd1);
        t = 1;
        readM = 1'b0; writeM = 1'b0; tb_drive = 1'b0;
        while (t < 30) begin
            step();
            checkOutput($sformatf("irq t=%0d", t), {15'b0, irq}, {15'b0, irq_exp(t)});
        end
        applyStimulus(1'b1, 1'b0, 16'hFF01, 16'h0);
        checkOutput("count live", data, 16'd9);
        applyStimulus(1'b0, 1'b0, 16'd0, 16'h0);
        applyStimulus(1'b1, 1'b0, 16'hFF02, 16'h0);
        checkOutput("ctrl pending", data, 16'd3);
        applyStimulus(1'b0, 1'b0, 16'd0, 16'h0);
        applyStimulus(1'b0, 1'b1, 16'hFF02, 16'd3);
        applyStimulus(1'b1, 1'b0, 16'hFF02, 16'h0);
        checkOutput("ctrl cleared", data, 16'd1);
        applyStimulus(1'b0, 1'b0, 16'd0, 16'h0);
        applyStimulus(1'b0, 1'b1, 16'hFF00, 16'd0);
        readM = 1'b0; writeM = 1'b0; tb_drive = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            checkOutput($sformatf("irq off %0d", i), {15'b0, irq}, 16'h0000);
        end
        applyStimulus(1'b1, 1'b0, 16'hFF01, 16'h0);
        checkOutput("count frozen", data, 16'd0);
        applyStimulus(1'b0, 1'b0, 16'd0, 16'h0);

        // LATENCY=4 instance: preload word 0, then a full read and an aborted one.
        write4 = 1'b1; addr4 = 16'd0; tb_data4 = 16'hABCD; tb_drive4 = 1'b1;
        step();
        write4 = 1'b0; tb_drive4 = 1'b0;
        step();
        read4 = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
            if (e == 1) addr4 = 16'd7;
            checkOutput($sformatf("lat4 edge%0d", e), {15'b0, ready4}, {15'b0, (e == 4)});
        end
        checkOutput("lat4 data", data4, 16'hABCD);
        read4 = 1'b0;
        step();
        checkOutput("lat4 drop ready", {15'b0, ready4}, 16'h0000);
        checkOutput("lat4 drop data", data4, 16'h0000);
        addr4 = 16'd0;
        read4 = 1'b1;
        step();
        read4 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checkOutput($sformatf("lat4 abort %0d", i), {15'b0, ready4}, 16'h0000);
        end
        read4 = 1'b1;
        repeat (3) step();
        checkOutput("lat4 retry early", {15'b0, ready4}, 16'h0000);
        step();
        checkOutput("lat4 retry ready", {15'b0, ready4}, 16'h0001);
        read4 = 1'b0;
        step();

        // Reset in READY releases the bus before the next edge; RAM survives.
        applyStimulus(1'b0, 1'b1, 16'hFF00, 16'd7);
        applyStimulus(1'b1, 1'b0, 16'd200, 16'h0);
        checkOutput("pre-reset data", data, 16'hBEEF);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("reset mid ready", {15'b0, inputReady}, 16'h0000);
        checkOutput("reset mid data", data, 16'h0000);
        readM = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 16'd200, 16'h0);
        checkOutput("ram200 after reset", data, 16'hBEEF);
        applyStimulus(1'b0, 1'b0, 16'd0, 16'h0);
        applyStimulus(1'b1, 1'b0, 16'd5, 16'h0);
        checkOutput("ram5 after reset", data, 16'h1234);
        applyStimulus(1'b0, 1'b0, 16'd0, 16'h0);
        applyStimulus(1'b1, 1'b0, 16'hFF00, 16'h0);
        checkOutput("period after reset", data, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'd0, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
